// File: rtl/jstk2_spi_master.sv
// SPI mode-0 master polling a PmodJSTK2: sends the LED colour command and
// decodes the returned X/Y position and button bytes.
module jstk2_spi_master #(
    parameter int unsigned CLK_DIV     = 12,
    parameter int unsigned SS_SETUP    = 180,
    parameter int unsigned BYTE_GAP    = 120,
    parameter int unsigned POLL_PERIOD = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    input  logic        miso,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic [1:0]  button,
    output logic        data_valid
);

    localparam int unsigned MAX_A = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int unsigned MAX_T = (MAX_A > BYTE_GAP) ? MAX_A : BYTE_GAP;
    localparam int unsigned CW    = $clog2(MAX_T + 1);
    localparam int unsigned PW    = $clog2(POLL_PERIOD);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    b0_q, b0_d;
    logic [1:0]    b1_q, b1_d;
    logic [7:0]    b2_q, b2_d;
    logic [1:0]    b3_q, b3_d;
    logic          ss_q, ss_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic [9:0]    xpos_q, xpos_d;
    logic [9:0]    ypos_q, ypos_d;
    logic [1:0]    btn_q, btn_d;
    logic          dv_q, dv_d;

    logic          poll_wrap;
    logic          req;
    logic [2:0]    nbit;
    logic [7:0]    txb;
    logic [7:0]    txn;

    function automatic logic [7:0] tx_byte(input logic [2:0]  idx,
                                           input logic [23:0] c);
        logic [7:0] b;
        unique case (idx)
            3'd0:    b = 8'h84;
            3'd1:    b = c[23:16];
            3'd2:    b = c[15:8];
            3'd3:    b = c[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign poll_wrap = (poll_q == POLL_LAST);
    assign req       = poll_wrap && enable;
    assign nbit      = bit_q - 3'd1;
    assign txb       = tx_byte(byte_q, rgb_q);
    assign txn       = tx_byte(byte_q + 3'd1, rgb_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            poll_q  <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= 3'd7;
            byte_q  <= 3'd0;
            rgb_q   <= 24'h0;
            sr_q    <= 8'h0;
            b0_q    <= 8'h0;
            b1_q    <= 2'b0;
            b2_q    <= 8'h0;
            b3_q    <= 2'b0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            xpos_q  <= 10'd512;
            ypos_q  <= 10'd512;
            btn_q   <= 2'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rgb_q   <= rgb_d;
            sr_q    <= sr_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            b3_q    <= b3_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            btn_q   <= btn_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        poll_d  = poll_wrap ? '0 : poll_q + 1'b1;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rgb_d   = rgb_q;
        sr_d    = sr_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        b3_d    = b3_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        btn_d   = btn_q;
        dv_d    = 1'b0;

        // A poll tick during a transfer is remembered and served from IDLE
        if (state_q != S_IDLE && req) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                ss_d = 1'b1;
                if (req || pend_q) begin
                    state_d = S_SETUP;
                    ss_d    = 1'b0;
                    cnt_d   = '0;
                    byte_d  = 3'd0;
                    rgb_d   = rgb;
                    pend_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    byte_d  = 3'd0;
                    mosi_d  = txb[7];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            case (byte_q)
                                3'd0:    b0_d = sr_q;
                                3'd1:    b1_d = sr_q[1:0];
                                3'd2:    b2_d = sr_q;
                                3'd3:    b3_d = sr_q[1:0];
                                default: ;
                            endcase
                            if (byte_q == 3'd4) begin
                                state_d = S_DONE;
                                ss_d    = 1'b1;
                                xpos_d  = {b1_q, b0_q};
                                ypos_d  = {b3_q, b2_q};
                                btn_d   = sr_q[1:0];
                                dv_d    = 1'b1;
                            end else begin
                                state_d = S_GAP;
                            end
                        end else begin
                            bit_d  = nbit;
                            mosi_d = txb[nbit];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    byte_d  = byte_q + 3'd1;
                    mosi_d  = txn[7];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign ss         = ss_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign button     = btn_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_jstk2_spi_master.sv
// Bench for jstk2_spi_master: SPI slave model, MOSI byte scoreboard and
// bus timing monitor around a table of polled transactions.
module tb_jstk2_spi_master;

    localparam int CLK_DIV     = 2;
    localparam int SS_SETUP    = 4;
    localparam int BYTE_GAP    = 3;
    localparam int POLL_PERIOD = 400;
    localparam int SS_LOW      = SS_SETUP + 5 * 16 * CLK_DIV + 4 * BYTE_GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] rgb = 24'h0;
    logic        miso;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic [1:0]  button;
    logic        data_valid;

    jstk2_spi_master #(
        .CLK_DIV    (CLK_DIV),
        .SS_SETUP   (SS_SETUP),
        .BYTE_GAP   (BYTE_GAP),
        .POLL_PERIOD(POLL_PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rgb       (rgb),
        .miso      (miso),
        .ss        (ss),
        .sclk      (sclk),
        .mosi      (mosi),
        .xpos      (xpos),
        .ypos      (ypos),
        .button    (button),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Joystick slave: shifts b0..b4 out on MISO, changing on SCLK fall
    logic [39:0] pat = {8'h34, 8'hFE, 8'h7F, 8'h01, 8'h03};
    int          sl_idx = 0;

    always @(ss or sclk) begin
        if (ss) begin
            sl_idx = 0;
            miso   = pat[39];
        end else if (sclk) begin
            sl_idx++;
        end else if (sl_idx < 40) begin
            miso = pat[39 - sl_idx];
        end
    end

    logic [7:0] exp_q[$];

    task automatic push_tx(input logic [23:0] c);
        exp_q.push_back(8'h84);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(8'h00);
    endtask

    // Bus monitor, sampled on the inactive clock edge
    int         cyc = 0;
    int         falls = 0;
    int         dv_cnt = 0;
    int         rises = 0;
    int         low_run = 0;
    int         high_run = 0;
    int         ss_low = 0;
    int         last_fall = 0;
    int         exp_low;
    logic       have_prev = 1'b0;
    logic       mon_on = 1'b1;
    logic       prev_ss = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       mosi_hold = 1'b0;
    logic [7:0] mbyte = 8'h0;

    always @(negedge clk) begin
        cyc++;
        if (data_valid === 1'b1) dv_cnt++;
        if (!mon_on) have_prev = 1'b0;
        if (prev_ss && ss === 1'b0) begin
            falls++;
            if (mon_on && have_prev)
                chk("ss_period", cyc - last_fall, POLL_PERIOD);
            last_fall = cyc;
            have_prev = 1'b1;
            rises     = 0;
            low_run   = 0;
            high_run  = 0;
            ss_low    = 0;
        end
        if (ss === 1'b0) begin
            ss_low++;
            if (sclk === 1'b1) begin
                if (!prev_sclk) begin
                    if (rises == 0) exp_low = SS_SETUP + CLK_DIV;
                    else if (rises % 8 == 0) exp_low = BYTE_GAP + CLK_DIV;
                    else exp_low = CLK_DIV;
                    if (mon_on) chk("sclk_low_run", low_run, exp_low);
                    rises++;
                    mbyte     = {mbyte[6:0], mosi};
                    mosi_hold = mosi;
                    high_run  = 0;
                    if (rises % 8 == 0 && mon_on) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL mosi_byte: got %0h expected none",
                                     mbyte);
                        end else begin
                            chk("mosi_byte", mbyte, exp_q.pop_front());
                        end
                    end
                end else if (mon_on) begin
                    chk("mosi_stable", mosi, mosi_hold);
                end
                high_run++;
                low_run = 0;
            end else begin
                if (prev_sclk && mon_on)
                    chk("sclk_high_run", high_run, CLK_DIV);
                low_run++;
            end
        end
        if (!prev_ss && ss === 1'b1 && mon_on) begin
            chk("ss_low_cycles", ss_low, SS_LOW);
            chk("sclk_rises", rises, 40);
        end
        prev_ss   = (ss !== 1'b0);
        prev_sclk = (sclk === 1'b1);
    end

    task automatic wait_dv(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (data_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (data_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_dv: got no pulse expected one in %0d cycles",
                     budget);
        end
    endtask

    task automatic wait_ss_low(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (ss !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ss !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_ss: got ss high expected fall in %0d cycles",
                     budget);
        end
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (rises < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rises < target) begin
            checks++;
            errors++;
            $display("FAIL wait_rises: got %0d expected %0d", rises, target);
        end
    endtask

    typedef struct {
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  b;
    } vec_t;

    vec_t vecs[4];
    int   fb;
    int   dvb;

    initial begin
        vecs[0] = '{rgb: 24'hFF8001, x: 10'h234, y: 10'h17F, b: 2'b11};
        vecs[1] = '{rgb: 24'h123456, x: 10'h234, y: 10'h17F, b: 2'b11};
        vecs[2] = '{rgb: 24'h000000, x: 10'h234, y: 10'h17F, b: 2'b11};
        vecs[3] = '{rgb: 24'hA5C35A, x: 10'h234, y: 10'h17F, b: 2'b11};

        #1 rst = 1'b1;
        #1;
        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_xpos", xpos, 512);
        chk("rst_ypos", ypos, 512);
        chk("rst_button", button, 0);
        chk("rst_dv", data_valid, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        repeat (450) @(negedge clk);
        #1;
        chk("idle_no_ss", falls, 0);

        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rgb = vecs[i].rgb;
            push_tx(vecs[i].rgb);
            wait_dv(1200);
            #1;
            chk("vec_xpos", xpos, vecs[i].x);
            chk("vec_ypos", ypos, vecs[i].y);
            chk("vec_button", button, vecs[i].b);
            chk("vec_queue_drained", exp_q.size(), 0);
        end
        chk("vec_dv_count", dv_cnt, 4);

        rgb = 24'hFF8001;
        push_tx(24'hFF8001);
        wait_ss_low(1200);
        wait_rises(10, 200);
        #1 rgb = 24'h000000;
        push_tx(24'h000000);
        wait_dv(1200);
        #1;
        chk("rgbchg_xpos", xpos, 10'h234);
        wait_dv(1200);
        #1;
        chk("rgbchg_ypos", ypos, 10'h17F);
        chk("rgbchg_queue_drained", exp_q.size(), 0);

        rgb = 24'h123456;
        push_tx(24'h123456);
        wait_ss_low(1200);
        wait_rises(18, 200);
        mon_on = 1'b0;
        dvb    = dv_cnt;
        #1 rst = 1'b1;
        #1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_xpos", xpos, 512);
        chk("midrst_ypos", ypos, 512);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("postrst_xpos", xpos, 512);
        chk("postrst_ypos", ypos, 512);
        chk("postrst_no_dv", dv_cnt, dvb);
        mon_on = 1'b1;
        push_tx(24'h123456);
        wait_dv(1200);
        #1;
        chk("postrst_xpos_new", xpos, 10'h234);
        chk("postrst_button", button, 2'b11);
        chk("postrst_queue_drained", exp_q.size(), 0);

        rgb = 24'hA5C35A;
        push_tx(24'hA5C35A);
        wait_ss_low(1200);
        #1 enable = 1'b0;
        fb  = falls;
        dvb = dv_cnt;
        wait_dv(600);
        #1;
        chk("endrop_ypos", ypos, 10'h17F);
        chk("endrop_dv_once", dv_cnt, dvb + 1);
        repeat (900) @(negedge clk);
        #1;
        chk("endrop_no_ss", falls, fb);
        chk("endrop_no_more_dv", dv_cnt, dvb + 1);
        chk("endrop_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jstk2_spi_master.md
Name: jstk2_spi_master

Overview:
- SPI mode-0 master that polls the PmodJSTK2 joystick module on a fixed period.
- Each 5-byte transaction sends the set-LED-RGB command and receives the X/Y position and button bytes.
- Decoded xpos/ypos/button feed the on-board LED indicator logic and any other joystick consumer.
- Runs on the 12 MHz iCEstick clock.

Parameters:
- CLK_DIV, 12, clk cycles per SCLK half-period (default gives 500 kHz SCLK).
- SS_SETUP, 180, clk cycles from SS falling to the first SCLK edge (15 us).
- BYTE_GAP, 120, clk cycles with SCLK idle low between bytes (10 us).
- POLL_PERIOD, 120000, clk cycles between transaction starts (10 ms). Must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  start polling when high
- rgb  in  24  LED colour {R[23:16], G[15:8], B[7:0]}
- miso  in  1  SPI data from the joystick
- ss  out  1  SPI chip select, active low
- sclk  out  1  SPI clock, idles low
- mosi  out  1  SPI data to the joystick
- xpos  out  10  X position, 0..1023
- ypos  out  10  Y position, 0..1023
- button  out  2  bit0 = stick press, bit1 = trigger
- data_valid  out  1  one-cycle pulse when xpos/ypos/button update

Behaviour:
- Reset values (all outputs registered): ss=1, sclk=0, mosi=0, xpos=512, ypos=512, button=0, data_valid=0, state=IDLE, poll counter=0. Centre values keep downstream threshold LEDs dark.
- Reset is asynchronous. Asserting rst mid-transaction aborts immediately to the reset values; no partial data is published.
- Poll counter:
  - Free-runs 0..POLL_PERIOD-1 and wraps.
  - A start is requested when the counter reaches POLL_PERIOD-1 while enable=1.
  - A request that arrives while a transaction is active is held and serviced on return to IDLE. At most one request is pending.
- Transmit bytes, MSB first: 0x84, rgb[23:16], rgb[15:8], rgb[7:0], 0x00. rgb is captured once at the IDLE->SETUP transition.
- Received bytes: b0..b4.
- States:
  - IDLE: ss=1. On a start request, go to SETUP and drive ss=0 on the same edge.
  - SETUP: hold SS_SETUP cycles, then go to SHIFT with bit index 7 and byte index 0.
  - SHIFT, per bit:
    - mosi valid for CLK_DIV cycles with sclk=0.
    - sclk=1 for CLK_DIV cycles.
    - miso is sampled into the shift register on the clk edge where sclk goes 0->1.
    - mosi changes only while sclk is low.
    - After the high phase of bit 0, sclk returns to 0.
    - Go to GAP if byte index < 4, otherwise DONE.
  - GAP: sclk=0 for BYTE_GAP cycles; increment the byte index; return to SHIFT.
  - DONE (1 cycle):
    - ss=1.
    - xpos = {b1[1:0], b0}; ypos = {b3[1:0], b2}; button = b4[1:0].
    - data_valid=1 for this single cycle.
    - Next state IDLE.
- All three data outputs update on the same edge and hold between transactions. Upper bits of b1, b3 and b4 are ignored.
- Transaction length, SS fall to DONE: SS_SETUP + 5*16*CLK_DIV + 4*BYTE_GAP cycles (1620 at defaults). SS stays high at least 1 cycle between transactions.
- enable deasserted mid-transaction: the current transaction completes normally, then the block stays in IDLE. Reasserting enable waits for the next counter wrap.
- Bit and byte counters are 3 bits wide; the half-period and setup/gap counters are sized to fit the largest parameter.

Test Plan:
- Bench parameters: CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=400. The SPI slave model returns bytes 0x34, 0xFE, 0x7F, 0x01, 0x03.
- Reset: after rst pulse, before any edge -> ss=1, sclk=0, mosi=0, xpos=512, ypos=512, button=0, data_valid=0; no SS activity while enable=0.
- Basic poll: enable=1, rgb=0xFF8001 -> MOSI bytes 0x84, 0xFF, 0x80, 0x01, 0x00. Then data_valid pulses once with xpos=0x234 (564), ypos=0x17F (383), button=2'b11. SS is low for exactly 4+160+12=176 cycles.
- Timing checks:
  - mosi is stable across every sclk high phase.
  - 8 rising SCLK edges per byte, 40 in total.
  - Gaps of 3 cycles between bytes with sclk low.
  - Consecutive ss falls are 400 cycles apart.
- rgb change mid-transfer: switch rgb to 0x000000 during byte 1 -> the current transaction still sends 0xFF, 0x80, 0x01; the next one sends 0x00 for all colour bytes.
- Reset mid-operation: assert rst during byte 2 -> ss=1 and sclk=0 immediately; xpos/ypos stay 512 and no data_valid pulse. The next transaction completes normally.
- enable drop: deassert enable during the SETUP state -> the transaction finishes with one data_valid pulse, and there are no further SS falls while enable=0.
